// File: rtl/remote_cmd_tx.sv
// Host-side command sender: serializes a 24-bit command as three UART 8N1
// frames, most-significant byte first, with one idle-high clock between frames.
module remote_cmd_tx #(
   parameter int unsigned BAUD_DIV = 2604
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        snd_cmd,
   input  logic [23:0] cmd,
   output logic        TX,
   output logic        busy,
   output logic        cmd_cmplt,
   output logic [1:0]  byte_cnt
);

   typedef enum logic [1:0] {IDLE, XMIT, NEXT} state_t;

   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

   state_t      state_q;
   logic [15:0] baud_q;
   logic [3:0]  bit_q;
   logic [9:0]  shift_q;
   // The top byte goes straight into the shifter on accept, so only the
   // two trailing bytes need holding.
   logic [15:0] hold_q;
   logic        tx_q;
   logic        busy_q;
   logic        cmplt_q;
   logic [1:0]  byte_q;
   logic [7:0]  next_byte;

   always_comb begin
      next_byte = (byte_q == 2'd0) ? hold_q[15:8] : hold_q[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '1;
         hold_q  <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         cmplt_q <= 1'b0;
         byte_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               tx_q <= 1'b1;
               if (snd_cmd) begin
                  hold_q  <= cmd[15:0];
                  shift_q <= {1'b1, cmd[23:16], 1'b0};
                  cmplt_q <= 1'b0;
                  busy_q  <= 1'b1;
                  byte_q  <= '0;
                  baud_q  <= '0;
                  bit_q   <= '0;
                  state_q <= XMIT;
               end
            end
            XMIT: begin
               tx_q <= shift_q[0];
               if (baud_q == BAUD_LAST) begin
                  baud_q  <= '0;
                  shift_q <= {1'b1, shift_q[9:1]};
                  bit_q   <= bit_q + 4'd1;
                  // Tenth terminal count closes the stop bit.
                  if (bit_q == 4'd9) state_q <= NEXT;
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            NEXT: begin
               tx_q <= 1'b1;
               if (byte_q == 2'd2) begin
                  busy_q  <= 1'b0;
                  cmplt_q <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  byte_q  <= byte_q + 2'd1;
                  shift_q <= {1'b1, next_byte, 1'b0};
                  bit_q   <= '0;
                  baud_q  <= '0;
                  state_q <= XMIT;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign TX        = tx_q;
   assign busy      = busy_q;
   assign cmd_cmplt = cmplt_q;
   assign byte_cnt  = byte_q;

endmodule

// File: doc/remote_cmd_tx.md
Name: remote_cmd_tx

Overview:
- Host-side command sender. Takes a 24-bit command and serializes it onto a UART TX line as three 8N1 frames, most-significant byte first.
- Its TX output drives the RX input of the command receiver, which shifts bytes in as {cmd[15:0], rx_data} and so needs byte order cmd[23:16], cmd[15:8], cmd[7:0].
- Contains its own baud timer, 10-bit frame shifter and 3-byte sequencer. It is used in testbenches and in the remote/host build.

Parameters:
- BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud). Legal range 4..65535.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- snd_cmd  input  1  single-cycle request to send cmd
- cmd  input  24  command word, sampled only on the accepted snd_cmd cycle
- TX  output  1  UART serial out; idle high
- busy  output  1  high while a 3-byte command is in flight
- cmd_cmplt  output  1  sticky; set when the last stop bit completes
- byte_cnt  output  2  index (0..2) of the byte currently being framed; debug and verification aid

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. All flops reset asynchronously.
- Reset values: TX=1, busy=0, cmd_cmplt=0, byte_cnt=0, FSM in IDLE, baud and bit counters = 0, shifter = all ones.
- FSM states are IDLE, XMIT, NEXT.
  - IDLE: when snd_cmd=1, latch cmd into a 24-bit hold register. Load the shifter with {1'b1, cmd[23:16], 1'b0}. Clear cmd_cmplt, set busy, byte_cnt=0, go to XMIT.
  - XMIT: TX = shifter[0]. The baud counter counts 0..BAUD_DIV-1. At terminal count, shift right filling with 1, increment the bit counter, and reset the baud counter. When the bit counter reaches 10 (stop bit fully elapsed), go to NEXT.
  - NEXT (one cycle, TX=1): if byte_cnt==2, clear busy, set cmd_cmplt, go to IDLE. Otherwise increment byte_cnt, load the shifter with the next hold byte (cmd[15:8], then cmd[7:0]) framed as above, clear the bit counter, go to XMIT.
- Frame format: start bit 0, 8 data bits LSB first, 1 stop bit. Every bit lasts exactly BAUD_DIV clocks.
- Latency:
  - TX falls on the first clk edge after the accepting edge.
  - Each frame is 10*BAUD_DIV clocks.
  - There is 1 idle-high clock between frames (the NEXT state).
  - cmd_cmplt rises exactly 30*BAUD_DIV+3 clocks after the accepting edge.
- snd_cmd while busy=1 is ignored entirely: the hold register, cmd_cmplt and the sequence are unaffected.
- cmd may change freely after acceptance; only the latched hold register is transmitted.
- cmd_cmplt stays high until the next accepted snd_cmd, which clears it on the same edge busy rises.
- snd_cmd on the same cycle NEXT returns to IDLE is not accepted (the FSM is not yet in IDLE). It must be re-issued.
- Reset mid-frame: TX returns to 1 immediately (asynchronous), the partial frame is abandoned, busy=0, cmd_cmplt=0.
- TX is driven from a flop, so it is glitch-free.

Test Plan (BAUD_DIV=16):
- Reset, then idle 100 clocks -> TX=1, busy=0, cmd_cmplt=0 throughout.
- snd_cmd with cmd=24'hA5_3C_0F -> serial bits decode to bytes 0xA5, 0x3C, 0x0F in that order. Each bit is 16 clocks, start=0, stop=1. cmd_cmplt rises at clock 483 after acceptance. Connected to the command receiver, its cmd equals 24'hA53C0F with cmd_rdy=1.
- snd_cmd with cmd=24'h123456, change cmd to 24'hFFFFFF on the next cycle, and pulse snd_cmd again mid-byte-1 -> bytes 0x12, 0x34, 0x56 only. No second transfer occurs; busy stays high continuously until completion.
- Back-to-back: issue snd_cmd one cycle after cmd_cmplt rises with cmd=24'h000001 -> cmd_cmplt clears on the accept edge, and the second command 0x00, 0x00, 0x01 is transmitted correctly.
- Assert rst_n=0 during bit 4 of byte 1 of cmd=24'hFFFFFF -> TX=1 within the same cycle, busy=0. A following snd_cmd with 24'h00FF00 transmits cleanly.
- Verify the inter-frame gap -> exactly 1 clock of TX=1 between each stop-bit end and the next start-bit fall. byte_cnt reads 0, 1, 2 during frames 0, 1, 2.
